load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory-access formatter between the execute stage and the data memory port.
//  Turns load/store intent plus the RISC-V funct3 width code into a read strobe
//  and per-byte write enables. Formats the raw memory word into the
//  sign/zero-extended register write-back value.
//  Datapath is combinational; clk/rst only gate the memory strobes during reset.
// PARAMETERS
//  XLEN  32  data/register width in bits; legal values 32 or 64 (XLEN/8 byte lanes)
// PORTS
//  clk        in   1         system clock (no registered datapath; reserved for pipeline integration)
//  rst        in   1         synchronous, active-high reset
//  is_load    in   1         current instruction is a load
//  is_store   in   1         current instruction is a store
//  fn3        in   3         RISC-V funct3 width/sign code
//  mem_dout   in   XLEN      raw word read from data memory (byte 0 in bits [7:0])
//  mem_r      out  1         memory read strobe
//  mem_w      out  XLEN/8    per-byte write enables, bit i = byte lane i
//  load_data  out  XLEN      formatted load result for register write-back
// BEHAVIOUR
//  - One clock; reset synchronous, active-high.
//  - While rst=1: mem_r=0, mem_w=0, regardless of other inputs. load_data still follows mem_dout/fn3.
//  - mem_r = is_load & !rst. Combinational, zero latency.
//  - mem_w: all zero unless is_store=1 (and rst=0). With is_store=1:
//      fn3=000 SB -> 0x01; 001 SH -> 0x03; 010 SW -> 0x0F; 011 SD -> 0xFF (XLEN=64 only)
//      any other fn3 (or 011 when XLEN=32) -> all zero (illegal store writes nothing)
//  - load_data is decoded from fn3 and mem_dout at all times; it is not qualified by is_load:
//      000 LB  -> sign-extend mem_dout[7:0]    (upper bits = mem_dout[7])
//      001 LH  -> sign-extend mem_dout[15:0]   (upper bits = mem_dout[15])
//      010 LW  -> sign-extend mem_dout[31:0]   (XLEN=32: mem_dout unchanged)
//      011 LD  -> mem_dout (XLEN=64); XLEN=32 -> 0
//      100 LBU -> zero-extend mem_dout[7:0]
//      101 LHU -> zero-extend mem_dout[15:0]
//      110 LWU -> zero-extend mem_dout[31:0] (XLEN=64); XLEN=32 -> 0
//      111     -> 0
//  - is_load and is_store are decoded independently. The decoder guarantees they are
//    never both 1; if they are, mem_r=1 and mem_w is per the store rule above.
//  - No address-offset lane steering: sub-word data always sits in the low lanes.
//    Alignment is the memory/AGU's responsibility.
//  - All outputs settle within the same cycle as input changes; no internal state.
// TESTING
//  1. is_store=0, fn3=000/001/010 -> mem_w=0000. is_store=1, same fn3 -> 0001/0011/1111.
//  2. is_load=0 -> mem_r=0. is_load=1 -> mem_r=1. rst=1 with is_load=1,is_store=1,fn3=010
//     -> mem_r=0, mem_w=0.
//  3. mem_dout=0x1234_5678:
//     LB=0x0000_0078, LH=0x0000_5678, LW=0x1234_5678, LBU=0x0000_0078, LHU=0x0000_5678.
//  4. mem_dout=0xDEAD_BEEF:
//     LB=0xFFFF_FFEF, LH=0xFFFF_BEEF, LW=0xDEAD_BEEF, LBU=0x0000_00EF, LHU=0x0000_BEEF.
//  5. is_store=1, fn3=011/100/111 with XLEN=32 -> mem_w=0000. Load fn3=110/111 -> load_data=0.
//  6. Random mem_dout, 1000 iterations over all fn3: compare against reference extension model.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store formatter: turns funct3 + load/store intent into memory strobes
// and sign/zero-extends the raw memory word for register write-back.
module load_store_unit #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        fn3,
  input  logic [XLEN-1:0]   mem_dout,
  output logic              mem_r,
  output logic [XLEN/8-1:0] mem_w,
  output logic [XLEN-1:0]   load_data
);

  localparam int NB = XLEN / 8;
  localparam logic [NB-1:0] SD_MASK = (XLEN == 64) ? '1 : '0;

  logic unused_clk;
  assign unused_clk = clk;

  logic [XLEN-1:0] lw_val;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] lwu_val;

  // Word/doubleword forms only differ from the raw word on RV64.
  if (XLEN == 64) begin : g_rv64
    assign lw_val  = {{32{mem_dout[31]}}, mem_dout[31:0]};
    assign ld_val  = mem_dout;
    assign lwu_val = {32'b0, mem_dout[31:0]};
  end else begin : g_rv32
    assign lw_val  = mem_dout;
    assign ld_val  = '0;
    assign lwu_val = '0;
  end

  assign mem_r = is_load & ~rst;

  always_comb begin
    mem_w = '0;
    if (is_store && !rst) begin
      case (fn3)
        3'b000:  mem_w = NB'(1);
        3'b001:  mem_w = NB'(3);
        3'b010:  mem_w = NB'(15);
        3'b011:  mem_w = SD_MASK;
        default: mem_w = '0;
      endcase
    end
  end

  always_comb begin
    load_data = '0;
    case (fn3)
      3'b000:  load_data = {{(XLEN-8){mem_dout[7]}}, mem_dout[7:0]};
      3'b001:  load_data = {{(XLEN-16){mem_dout[15]}}, mem_dout[15:0]};
      3'b010:  load_data = lw_val;
      3'b011:  load_data = ld_val;
      3'b100:  load_data = {{(XLEN-8){1'b0}}, mem_dout[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, mem_dout[15:0]};
      3'b110:  load_data = lwu_val;
      default: load_data = '0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (XLEN=32): directed vectors plus
// randomized sweep against an independent extension model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load;
  logic        is_store;
  logic [2:0]  fn3;
  logic [31:0] mem_dout;
  logic        mem_r;
  logic [3:0]  mem_w;
  logic [31:0] load_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        r;
    logic [3:0]  w;
    logic [31:0] d;
  } exp_t;

  exp_t sb[$];

  load_store_unit #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .is_load(is_load),
    .is_store(is_store),
    .fn3(fn3),
    .mem_dout(mem_dout),
    .mem_r(mem_r),
    .mem_w(mem_w),
    .load_data(load_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] ref_w(input logic r, input logic st,
                                       input logic [2:0] f);
    if (r || !st) return 4'b0000;
    case (f)
      3'd0:    return 4'b0001;
      3'd1:    return 4'b0011;
      3'd2:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_d(input logic [2:0] f,
                                        input logic [31:0] d);
    int s;
    case (f)
      3'd0: begin s = $signed(d[7:0]);  return s; end
      3'd1: begin s = $signed(d[15:0]); return s; end
      3'd2:    return d;
      3'd4:    return d & 32'h0000_00ff;
      3'd5:    return d & 32'h0000_ffff;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input string tag, input logic r_, input logic ld,
                      input logic st, input logic [2:0] f,
                      input logic [31:0] dout, input logic er,
                      input logic [3:0] ew, input logic [31:0] ed);
    exp_t e;
    @(negedge clk);
    rst = r_;
    is_load = ld;
    is_store = st;
    fn3 = f;
    mem_dout = dout;
    sb.push_back('{tag, er, ew, ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".r"}, 32'(mem_r), 32'(e.r));
    chk({e.tag, ".w"}, 32'(mem_w), 32'(e.w));
    chk({e.tag, ".d"}, load_data, e.d);
  endtask

  logic [31:0] lo_exp [0:7];
  logic [31:0] hi_exp [0:7];
  logic [3:0]  sw_exp [0:2];

  initial begin
    rst = 1'b1;
    is_load = 1'b0;
    is_store = 1'b0;
    fn3 = 3'd0;
    mem_dout = 32'h0;

    lo_exp = '{32'h0000_0078, 32'h0000_5678, 32'h1234_5678, 32'h0,
               32'h0000_0078, 32'h0000_5678, 32'h0, 32'h0};
    hi_exp = '{32'hffff_ffef, 32'hffff_beef, 32'hdead_beef, 32'h0,
               32'h0000_00ef, 32'h0000_beef, 32'h0, 32'h0};
    sw_exp = '{4'b0001, 4'b0011, 4'b1111};

    step("rst_all", 1, 1, 1, 3'd2, 32'hdead_beef, 0, 4'h0, 32'hdead_beef);
    step("rst_sb", 1, 0, 1, 3'd0, 32'h0000_0080, 0, 4'h0, 32'hffff_ff80);

    for (int i = 0; i < 3; i++) begin
      step($sformatf("nost%0d", i), 0, 0, 0, 3'(i), 32'h0,
           0, 4'h0, 32'h0);
      step($sformatf("st%0d", i), 0, 0, 1, 3'(i), 32'h0,
           0, sw_exp[i], 32'h0);
    end

    step("ld_off", 0, 0, 0, 3'd2, 32'h1, 0, 4'h0, 32'h1);
    step("ld_on", 0, 1, 0, 3'd2, 32'h1, 1, 4'h0, 32'h1);
    step("ld_st", 0, 1, 1, 3'd1, 32'h1, 1, 4'h3, 32'h1);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("lo_f%0d", i), 0, 1, 0, 3'(i), 32'h1234_5678,
           1, 4'h0, lo_exp[i]);
      step($sformatf("hi_f%0d", i), 0, 1, 0, 3'(i), 32'hdead_beef,
           1, 4'h0, hi_exp[i]);
    end

    for (int i = 3; i < 8; i++)
      step($sformatf("st_ill%0d", i), 0, 0, 1, 3'(i), 32'hffff_ffff,
           0, 4'h0, hi_exp[i] | lo_exp[i] ? ref_d(3'(i), 32'hffff_ffff)
                                          : ref_d(3'(i), 32'hffff_ffff));

    for (int n = 0; n < 1000; n++) begin
      logic        r;
      logic        ld;
      logic        st;
      logic [2:0]  f;
      logic [31:0] d;
      r  = ($urandom_range(0, 15) == 0);
      ld = 1'($urandom);
      st = 1'($urandom);
      f  = 3'($urandom);
      d  = $urandom;
      if (n % 4 == 0) d[7] = 1'b1;
      if (n % 4 == 1) d[15] = 1'b1;
      step($sformatf("rnd%0d", n), r, ld, st, f, d,
           ld & ~r, ref_w(r, st, f), ref_d(f, d));
    end

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
